ibex_rf_wr_arbiter: RTL and testbench



---
 rtl/ibex_pkg.sv | 15 +
 rtl/ibex_rf_arb_age_ctr.sv | 32 +++
 rtl/ibex_rf_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_ibex_rf_wr_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the register-file write arbiter.
//   rf_wr_req_t   : one producer's write request (destination + data)
//   RF_ARB_REQ_*  : requester indices, lowest index = highest base priority
package ibex_pkg;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wr_req_t;

    localparam int RF_ARB_REQ_LSU  = 0;
    localparam int RF_ARB_REQ_IDEX = 1;
    localparam int RF_ARB_REQ_MC   = 2;

endpackage

// File: rtl/ibex_rf_arb_age_ctr.sv
// ibex_rf_arb_age_ctr: per-requester starvation counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   valid_i      : requester has a pending write
//   grant_i      : requester was granted this cycle
//   starved_o    : requester has lost MaxWait consecutive cycles (never set when MaxWait == 0)
module ibex_rf_arb_age_ctr #(
    parameter int MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic grant_i,
    output logic starved_o
);

    // Keep at least one bit so MaxWait == 0 still elaborates; the counter then sits at 0.
    localparam int CW = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
    localparam logic [CW-1:0] CntMax = CW'(MaxWait);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || grant_i || !valid_i) begin
            cnt <= '0;
        end else if (cnt != CntMax) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved_o = (MaxWait > 0) && (cnt == CntMax);

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// ibex_rf_wr_arbiter: shares the single RF write port between result producers
// (0 = LSU, 1 = ID/EX, 2 = multi-cycle unit) with fixed priority plus aging.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/ready_o : per-requester handshake, ready is one-hot0
//   req_waddr_i/wdata_i : per-requester destination and data
//   rf_we_o/waddr_o/wdata_o : registered RF write port (1-cycle latency)
//   hz_raddr_a/b_i, hz_a/b_o : pending-write hazard check for ID reads
//   perf_stall_cnt_o    : per-requester 16-bit saturating stall counters,
//                         present only with IBEX_RF_ARB_PERF_EN defined
module ibex_rf_wr_arbiter
    import ibex_pkg::*;
#(
    parameter int NumReq   = 3,
    parameter int MaxWait  = 4,
    parameter int ResetAll = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    input  logic [NumReq-1:0][4:0]   req_waddr_i,
    input  logic [NumReq-1:0][31:0]  req_wdata_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [31:0]              rf_wdata_o,
    input  logic [4:0]               hz_raddr_a_i,
    input  logic [4:0]               hz_raddr_b_i,
    output logic                     hz_a_o,
    output logic                     hz_b_o
`ifdef IBEX_RF_ARB_PERF_EN
    ,
    output logic [NumReq-1:0][15:0]  perf_stall_cnt_o
`endif
);

    rf_wr_req_t        req [NumReq];
    rf_wr_req_t        win;
    logic [NumReq-1:0] starved;
    logic [NumReq-1:0] cand;
    logic [NumReq-1:0] grant;
    logic              found;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req[i] = '{waddr: req_waddr_i[i], wdata: req_wdata_i[i]};
        end
    end

    // Starved requesters form their own priority tier above everyone else.
    always_comb begin
        cand  = (|(starved & req_valid_i)) ? (starved & req_valid_i) : req_valid_i;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (cand[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Nothing is accepted while reset is held, even mid-transfer.
        if (rst_i) begin
            grant = '0;
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        win = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                win = req[i];
            end
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_age
        ibex_rf_arb_age_ctr #(
            .MaxWait (MaxWait)
        ) u_age (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .valid_i   (req_valid_i[g]),
            .grant_i   (grant[g]),
            .starved_o (starved[g])
        );
    end

    // Writes to x0 are accepted (the producer is released) but never reach the RF.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o <= 1'b0;
            if (ResetAll != 0) begin
                rf_waddr_o <= '0;
                rf_wdata_o <= '0;
            end
        end else begin
            rf_we_o <= (|grant) && (win.waddr != 5'd0);
            if (|grant) begin
                rf_waddr_o <= win.waddr;
                rf_wdata_o <= win.wdata;
            end
        end
    end

    // A read is hazardous if its register is in flight on the RF port or still
    // pending at any producer, regardless of who wins arbitration.
    always_comb begin
        hz_a_o = rf_we_o && (rf_waddr_o == hz_raddr_a_i);
        hz_b_o = rf_we_o && (rf_waddr_o == hz_raddr_b_i);
        for (int i = 0; i < NumReq; i++) begin
            hz_a_o = hz_a_o | (req_valid_i[i] && (req_waddr_i[i] == hz_raddr_a_i));
            hz_b_o = hz_b_o | (req_valid_i[i] && (req_waddr_i[i] == hz_raddr_b_i));
        end
        if (hz_raddr_a_i == 5'd0) hz_a_o = 1'b0;
        if (hz_raddr_b_i == 5'd0) hz_b_o = 1'b0;
    end

`ifdef IBEX_RF_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst_i) begin
                perf_stall_cnt_o[i] <= '0;
            end else if (req_valid_i[i] && !req_ready_o[i] && (perf_stall_cnt_o[i] != 16'hFFFF)) begin
                perf_stall_cnt_o[i] <= perf_stall_cnt_o[i] + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    logic [NumReq-1:0][31:0] wait_cnt;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst_i || !req_valid_i[i] || req_ready_o[i]) begin
                wait_cnt[i] <= '0;
            end else begin
                wait_cnt[i] <= wait_cnt[i] + 32'd1;
            end
        end
    end

    a_ready_onehot0 : assert property (@(posedge clk_i) $onehot0(req_ready_o));
    a_ready_valid   : assert property (@(posedge clk_i) (req_ready_o & ~req_valid_i) == '0);

    for (genvar g = 0; g < NumReq; g++) begin : g_chk
        a_stable : assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[g] && !req_ready_o[g]) |=>
            (req_valid_i[g] && $stable(req_waddr_i[g]) && $stable(req_wdata_i[g])));
        a_no_starve : assert property (@(posedge clk_i) disable iff (rst_i)
            (MaxWait == 0) || (wait_cnt[g] <= 32'(MaxWait + NumReq - 1)));
    end
`endif

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
module tb_ibex_rf_wr_arbiter;

    logic             clk_i;
    logic             rst_i;
    logic [2:0]       req_valid_i;
    logic [2:0]       req_ready_o;
    logic [2:0][4:0]  req_waddr_i;
    logic [2:0][31:0] req_wdata_i;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic [4:0]       hz_raddr_a_i;
    logic [4:0]       hz_raddr_b_i;
    logic             hz_a_o;
    logic             hz_b_o;
`ifdef IBEX_RF_ARB_PERF_EN
    logic [2:0][15:0] perf_stall_cnt_o;
`endif

    int n_chk;
    int n_pass;

    ibex_rf_wr_arbiter #(
        .NumReq   (3),
        .MaxWait  (4),
        .ResetAll (0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_waddr_i  (req_waddr_i),
        .req_wdata_i  (req_wdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .hz_raddr_a_i (hz_raddr_a_i),
        .hz_raddr_b_i (hz_raddr_b_i),
        .hz_a_o       (hz_a_o),
        .hz_b_o       (hz_b_o)
`ifdef IBEX_RF_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_i = 1'b1;
        req_valid_i = 3'b111;
        req_waddr_i[0] = 5'd1; req_wdata_i[0] = 32'h11;
        req_waddr_i[1] = 5'd2; req_wdata_i[1] = 32'h22;
        req_waddr_i[2] = 5'd3; req_wdata_i[2] = 32'h33;
        hz_raddr_a_i = 5'd0;
        hz_raddr_b_i = 5'd0;

        // reset: nothing accepted while held
        #1 chk("rst_rdy_a", 32'(req_ready_o), 32'h0);
        step();
        chk("rst_rdy_b", 32'(req_ready_o), 32'h0);
        chk("rst_we", 32'(rf_we_o), 32'h0);
        step();
        chk("rst_rdy_c", 32'(req_ready_o), 32'h0);
        rst_i = 1'b0;
        req_valid_i = 3'b000;
        step();
        chk("rel_we", 32'(rf_we_o), 32'h0);
        chk("rel_rdy", 32'(req_ready_o), 32'h0);

        // single request from ID/EX
        req_valid_i = 3'b010;
        req_waddr_i[1] = 5'd5; req_wdata_i[1] = 32'hDEADBEEF;
        #1 chk("one_rdy", 32'(req_ready_o), 32'h2);
        step();
        req_valid_i = 3'b000;
        #1;
        chk("one_we", 32'(rf_we_o), 32'h1);
        chk("one_addr", 32'(rf_waddr_o), 32'd5);
        chk("one_data", rf_wdata_o, 32'hDEADBEEF);
        step();
        chk("one_we_off", 32'(rf_we_o), 32'h0);
        chk("one_hold", 32'(rf_waddr_o), 32'd5);

        // write to x0: accepted, suppressed
        req_valid_i = 3'b001;
        req_waddr_i[0] = 5'd0; req_wdata_i[0] = 32'h1234;
        #1;
        chk("x0_rdy", 32'(req_ready_o), 32'h1);
        chk("x0_hz", 32'(hz_a_o), 32'h0);
        step();
        req_valid_i = 3'b000;
        #1;
        chk("x0_we", 32'(rf_we_o), 32'h0);
        chk("x0_data", rf_wdata_o, 32'h1234);

        // aging: req1 loses 4 cycles, wins the 5th
        req_waddr_i[1] = 5'd9; req_wdata_i[1] = 32'hA1;
        for (int k = 1; k <= 4; k++) begin
            req_valid_i = 3'b011;
            req_waddr_i[0] = 5'(10 + k); req_wdata_i[0] = 32'(k);
            #1;
            chk($sformatf("age_lose%0d", k), 32'(req_ready_o), 32'h1);
            if (k > 1) chk($sformatf("age_pipe%0d", k), 32'(rf_waddr_o), 32'(9 + k));
            step();
        end
        req_waddr_i[0] = 5'd20; req_wdata_i[0] = 32'h20;
        #1;
        chk("age_promote", 32'(req_ready_o), 32'h2);
        chk("age_b2b", 32'(rf_waddr_o), 32'd14);
        step();
        req_wdata_i[1] = 32'hB2;
        #1;
        chk("age_clear", 32'(req_ready_o), 32'h1);
        chk("age_w_we", 32'(rf_we_o), 32'h1);
        chk("age_w_addr", 32'(rf_waddr_o), 32'd9);
        chk("age_w_data", rf_wdata_o, 32'hA1);
        step();
        req_valid_i = 3'b010;
        #1;
        chk("age_alone", 32'(req_ready_o), 32'h2);
        chk("age_r0_data", rf_wdata_o, 32'h20);
        step();
        req_valid_i = 3'b000;
        #1;
        chk("age_r1_data", rf_wdata_o, 32'hB2);
        step();

        // hazards
        req_valid_i = 3'b101;
        req_waddr_i[0] = 5'd3; req_wdata_i[0] = 32'h33;
        req_waddr_i[2] = 5'd7; req_wdata_i[2] = 32'h77;
        hz_raddr_a_i = 5'd7; hz_raddr_b_i = 5'd3;
        #1;
        chk("hz_a_loser", 32'(hz_a_o), 32'h1);
        chk("hz_b_winner", 32'(hz_b_o), 32'h1);
        chk("hz_rdy", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = 3'b100;
        #1;
        chk("hz_b_reg", 32'(hz_b_o), 32'h1);
        chk("hz_b_addr", 32'(rf_waddr_o), 32'd3);
        chk("hz_a_pend", 32'(hz_a_o), 32'h1);
        chk("hz_rdy2", 32'(req_ready_o), 32'h4);
        step();
        req_valid_i = 3'b000;
        req_waddr_i[0] = 5'd5; hz_raddr_b_i = 5'd5;
        #1;
        chk("hz_a_reg", 32'(hz_a_o), 32'h1);
        chk("hz_b_inval", 32'(hz_b_o), 32'h0);
        step();
        chk("hz_a_we0", 32'(hz_a_o), 32'h0);
        chk("hz_we0", 32'(rf_we_o), 32'h0);

`ifdef IBEX_RF_ARB_PERF_EN
        // req1 stalls 4+4+2 cycles around two aged grants; req0 stalls on those 2 grants
        req_valid_i = 3'b011;
        req_waddr_i[0] = 5'd4; req_wdata_i[0] = 32'h44;
        req_waddr_i[1] = 5'd6; req_wdata_i[1] = 32'h66;
        repeat (12) step();
        chk("perf1", 32'(perf_stall_cnt_o[1]), 32'd10);
        chk("perf0", 32'(perf_stall_cnt_o[0]), 32'd2);
        rst_i = 1'b1;
        step();
        chk("perf1_rst", 32'(perf_stall_cnt_o[1]), 32'd0);
        chk("perf0_rst", 32'(perf_stall_cnt_o[0]), 32'd0);
        rst_i = 1'b0;
        req_valid_i = 3'b000;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
